pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit datapath. It decides each cycle whether the PC and the IF/ID buffer advance, hold or flush, and whether ID/EX receives a bubble. It covers load-use hazards, taken-branch flushes and multi-cycle mul/div stalls. It sits beside the IF/ID and ID/EX buffers and drives their write-enable, flush and bubble inputs.

---
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF-ID / ID-EX control for load-use stalls,
// taken-branch flushes and multi-cycle mul/div stalls.
module pipeline_hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int FLUSH_CYC = 2,
    parameter int MD_LAT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_md,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush_n,
    output logic             idex_bubble,
    output logic             md_start,
    output logic             md_done,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_BR_FLUSH = 2'd1,
        S_MD_WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYC - 1);
    localparam logic [15:0] MD_LOAD    = 16'(MD_LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        md_served_q, md_served_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

    assign load_use = ex_memread && (ex_rd != '0) && id_valid &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush_n = 1'b1;
        idex_bubble  = 1'b0;
        md_start     = 1'b0;
        md_done      = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_served_d  = md_served_q;

        unique case (state_q)
            S_RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush_n = 1'b0;
                    idex_bubble  = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = S_BR_FLUSH;
                    end
                end else if (id_valid && id_is_md && !md_served_q) begin
                    md_start    = 1'b1;
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = MD_LOAD;
                    state_d     = S_MD_WAIT;
                end else if (load_use) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
                // The served flag only protects the mul/div still sitting in ID.
                if (ifid_we) md_served_d = 1'b0;
            end
            S_BR_FLUSH: begin
                ifid_flush_n = 1'b0;
                idex_bubble  = 1'b1;
                if (cnt_q == 16'd1) state_d = S_RUN;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_MD_WAIT: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (cnt_q == 16'd1) begin
                    md_done     = 1'b1;
                    md_served_d = 1'b1;
                    state_d     = S_RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;

        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush_n = 1'b0;
            idex_bubble  = 1'b1;
            md_start     = 1'b0;
            md_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            md_served_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_served_q <= md_served_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REG_W=4, FLUSH_CYC=2, MD_LAT=4):
// a per-cycle vector table plus hand-written reset sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rt, id_is_md, ex_memread, ex_branch_taken;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        pc_we, ifid_we, ifid_flush_n, idex_bubble, md_start, md_done;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(4), .FLUSH_CYC(2), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_md(id_is_md), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush_n(ifid_flush_n),
        .idex_bubble(idex_bubble), .md_start(md_start), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        uses_rt;
        logic        is_md;
        logic        memread;
        logic [3:0]  rd;
        logic        br;
        logic        e_pc;
        logic        e_ifid;
        logic        e_fln;
        logic        e_bub;
        logic        e_start;
        logic        e_done;
        logic [15:0] e_sc;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic urt, input logic md, input logic mr,
                         input logic [3:0] rd, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_md = md;
        ex_memread = mr; ex_rd = rd; ex_branch_taken = br;
    endtask

    task automatic chk_outs(input string tag, input logic p, input logic w, input logic f,
                            input logic b, input logic s, input logic d, input logic [15:0] sc);
        chk({tag, " pc_we"}, 16'(pc_we), 16'(p));
        chk({tag, " ifid_we"}, 16'(ifid_we), 16'(w));
        chk({tag, " ifid_flush_n"}, 16'(ifid_flush_n), 16'(f));
        chk({tag, " idex_bubble"}, 16'(idex_bubble), 16'(b));
        chk({tag, " md_start"}, 16'(md_start), 16'(s));
        chk({tag, " md_done"}, 16'(md_done), 16'(d));
        chk({tag, " stall_cnt"}, stall_cnt, sc);
    endtask

    initial begin
        //           valid rs rt urt md mr rd br | pc ifid fln bub st dn sc
        vec[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0};  // idle
        vec[1]  = '{1, 3, 0, 0, 0, 1, 3, 0,  0, 0, 1, 1, 0, 0, 0};  // load-use on rs
        vec[2]  = '{1, 3, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 1};  // bubble cleared it
        vec[3]  = '{1, 0, 0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 0, 1};  // rd zero: no stall
        vec[4]  = '{1, 1, 5, 1, 0, 1, 5, 0,  0, 0, 1, 1, 0, 0, 1};  // load-use on rt
        vec[5]  = '{1, 1, 5, 0, 0, 1, 5, 0,  1, 1, 1, 0, 0, 0, 2};  // rt not read
        vec[6]  = '{0, 5, 0, 0, 0, 1, 5, 0,  1, 1, 1, 0, 0, 0, 2};  // id not valid
        vec[7]  = '{0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 0, 2};  // branch T
        vec[8]  = '{1, 3, 0, 0, 1, 1, 3, 0,  1, 1, 0, 1, 0, 0, 2};  // BR_FLUSH ignores inputs
        vec[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 2};  // back in RUN
        vec[10] = '{1, 2, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 1, 0, 2};  // md_start T
        vec[11] = '{1, 2, 0, 0, 1, 0, 0, 1,  0, 0, 1, 1, 0, 0, 3};  // branch ignored
        vec[12] = '{1, 2, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 4};
        vec[13] = '{1, 2, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 1, 5};  // md_done T+3
        vec[14] = '{1, 2, 0, 0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 6};  // advances, no restart
        vec[15] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 6};
        vec[16] = '{1, 3, 0, 0, 1, 1, 3, 1,  1, 1, 0, 1, 0, 0, 6};  // branch beats LU+md
        vec[17] = '{1, 3, 0, 0, 1, 1, 3, 0,  1, 1, 0, 1, 0, 0, 6};
        vec[18] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 6};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_outs("reset", 0, 0, 0, 1, 0, 0, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].valid, vec[i].rs, vec[i].rt, vec[i].uses_rt, vec[i].is_md,
                  vec[i].memread, vec[i].rd, vec[i].br);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vec[i].e_pc, vec[i].e_ifid, vec[i].e_fln,
                     vec[i].e_bub, vec[i].e_start, vec[i].e_done, vec[i].e_sc);
            @(posedge clk);
            #1;
        end

        // Reset two cycles into a mul/div stall.
        drive(1, 2, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk_outs("rmd T", 0, 0, 1, 1, 1, 0, 16'd6);
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs("rmd T+1", 0, 0, 1, 1, 0, 0, 16'd7);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_outs("rmd rst", 0, 0, 0, 1, 0, 0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rmd hold%0d md_done", k), 16'(md_done), 16'd0);
            chk($sformatf("rmd hold%0d stall_cnt", k), stall_cnt, 16'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk_outs("rmd release", 1, 1, 1, 0, 0, 0, 16'd0);
        @(posedge clk); #1;
        // Back in RUN with md_served clear: a fresh mul/div launches at once.
        drive(1, 2, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk_outs("rmd relaunch", 0, 0, 1, 1, 1, 0, 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmd relaunch cnt", stall_cnt, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
